wb_stage: RTL and testbench

Writeback stage of the five-stage pipelined RV32I core. Holds the MEM/WB pipeline register. Aligns and sign/zero-extends load data, then selects the writeback source. Drives the register file write port (wa/we/wd) and exposes retire information (valid, PC, retired-instruction count) to the PDU.

---
 rtl/wb_stage.sv | 103 ++++++++++
 tb/tb_wb_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load alignment/extension,
// writeback source select, register-file write port and retire counter.
module wb_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hold,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic [WIDTH-1:0] mem_alu_res,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [DEPTH-1:0] mem_rd,
    input  logic             mem_rf_we,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    output logic [DEPTH-1:0] rf_wa,
    output logic             rf_we,
    output logic [WIDTH-1:0] rf_wd,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_pc,
    output logic [31:0]      retire_cnt
);

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] wd_next;

    logic             valid_q;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] wd_q;
    logic [DEPTH-1:0] rd_q;
    logic             we_q;
    logic [31:0]      cnt_q;

    // Align the loaded word to the addressed byte/half and extend it.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (mem_alu_res[1:0])
            2'b00:   ld_byte = mem_rdata[7:0];
            2'b01:   ld_byte = mem_rdata[15:8];
            2'b10:   ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        // Bit 0 of the address is ignored for halfword loads.
        ld_half = mem_alu_res[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mem_funct3)
            3'b000:  ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    // Pick the writeback source: load data, link address, or ALU result.
    always_comb begin
        case (mem_wb_sel)
            2'b01:   wd_next = ld_val;
            2'b10:   wd_next = mem_pc + WIDTH'(4);
            default: wd_next = mem_alu_res;
        endcase
    end

    // MEM/WB register: flush kills the entry, hold freezes it, else capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (!hold) begin
            valid_q <= mem_valid;
            pc_q    <= mem_pc;
            wd_q    <= wd_next;
            rd_q    <= mem_rd;
            we_q    <= mem_rf_we;
        end
    end

    // Count an instruction when it leaves WB; a flushed-while-held entry never leaves.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (valid_q && !hold) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign rf_wa      = rd_q;
    assign rf_wd      = wd_q;
    assign rf_we      = valid_q & we_q & (rd_q != '0);
    assign wb_valid   = valid_q;
    assign wb_pc      = pc_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage against a behavioural writeback model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hold, flush, mem_valid, mem_rf_we;
    logic [31:0] mem_pc, mem_alu_res, mem_rdata;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [4:0]  rf_wa;
    logic        rf_we, wb_valid;
    logic [31:0] rf_wd, wb_pc, retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the WB entry and the retire count
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_wd, m_cnt;
    logic [4:0]  m_rd;

    wb_stage #(.WIDTH(32), .DEPTH(5)) dut (
        .clk(clk), .rstn(rstn), .hold(hold), .flush(flush),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_alu_res(mem_alu_res),
        .mem_rdata(mem_rdata), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Writeback value computed from the ISA rules with plain arithmetic
    function automatic logic [31:0] ref_value(input logic [1:0] sel, input logic [31:0] pc,
                                              input logic [31:0] alu, input logic [31:0] rdata,
                                              input logic [2:0] f3);
        int unsigned bval, hval;
        bval = (rdata >> (8 * (alu % 4))) & 32'hFF;
        hval = (rdata >> (16 * ((alu / 2) % 2))) & 32'hFFFF;
        if (sel == 2'd1) begin
            if (f3 == 3'd0) return (bval >= 128) ? bval + 32'hFFFF_FF00 : bval;
            if (f3 == 3'd4) return bval;
            if (f3 == 3'd1) return (hval >= 32768) ? hval + 32'hFFFF_0000 : hval;
            if (f3 == 3'd5) return hval;
            return rdata;
        end
        if (sel == 2'd2) return pc + 32'd4;
        return alu;
    endfunction

    function automatic logic exp_rf_we();
        return m_valid && m_we && (m_rd != 5'd0);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_we = 0; m_pc = 0; m_wd = 0; m_rd = 0; m_cnt = 0;
    endtask

    // One clock: apply inputs after negedge, advance model at posedge, return 1 time unit later
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] f3, input logic h, input logic f);
        @(negedge clk);
        mem_valid = v; mem_pc = pc; mem_alu_res = alu; mem_rdata = rdata; mem_rd = rd;
        mem_rf_we = we; mem_wb_sel = sel; mem_funct3 = f3; hold = h; flush = f;
        @(posedge clk);
        if (m_valid && !h) m_cnt = m_cnt + 32'd1;
        if (f) begin
            m_valid = 0;
        end else if (!h) begin
            m_valid = v; m_pc = pc; m_rd = rd; m_we = we;
            m_wd = ref_value(sel, pc, alu, rdata, f3);
        end
        #1;
    endtask

    task automatic bubble();
        cyc(0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 2'd0, 3'd0, 0, 0);
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        // Outputs read zero as soon as reset asserts, before any edge
        rstn = 0;
        #1;
        n_tests++;
        if ({rf_wa, rf_we, rf_wd, wb_valid, wb_pc, retire_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_initial got wd=%h pc=%h cnt=%h exp all zero", rf_wd, wb_pc, retire_cnt);
        end
        model_reset();
        @(posedge clk); #2; rstn = 1;
        exp_pc = 32'h0000_0400;
        cyc(1, exp_pc, 32'h1234, 32'h0, 5'd5, 1, 2'd0, 3'd0, 0, 0);
        n_tests++;
        if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h1234 || wb_pc !== exp_pc) begin
            n_fail++; $display("FAIL reset_first_op got we=%b wa=%0d wd=%h pc=%h exp we=1 wa=5 wd=00001234 pc=%h",
                               rf_we, rf_wa, rf_wd, wb_pc, exp_pc);
        end
        n_tests++;
        if (retire_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt_before got %h exp 0", retire_cnt);
        end
        bubble();
        n_tests++;
        if (retire_cnt !== 32'd1) begin
            n_fail++; $display("FAIL reset_cnt_after got %h exp 1", retire_cnt);
        end
        // Asynchronous reset mid-cycle with a live entry
        cyc(1, 32'h500, 32'hABCD, 32'h0, 5'd7, 1, 2'd0, 3'd0, 1, 0);
        cyc(1, 32'h504, 32'hABCE, 32'h0, 5'd8, 1, 2'd0, 3'd0, 0, 0);
        #1; rstn = 0; #1;
        n_tests++;
        if ({rf_wa, rf_we, rf_wd, wb_valid, wb_pc, retire_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_async got wa=%0d wd=%h valid=%b pc=%h cnt=%h exp all zero",
                               rf_wa, rf_wd, wb_valid, wb_pc, retire_cnt);
        end
        model_reset();
        @(posedge clk); #2; rstn = 1;
    endtask

    task automatic test_load();
        logic [31:0] addr [6];
        logic [2:0]  f3   [6];
        logic [31:0] expv [6];
        addr = '{32'h1001, 32'h1003, 32'h1002, 32'h1002, 32'h1000, 32'h1000};
        f3   = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        expv = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 6; i++) begin
            cyc(1, 32'h200 + 32'(4 * i), addr[i], 32'h80FF_7F01, 5'd10, 1, 2'd1, f3[i], 0, 0);
            n_tests++;
            if (rf_wd !== expv[i] || rf_we !== 1'b1) begin
                n_fail++; $display("FAIL load_%0d got wd=%h we=%b exp wd=%h we=1", i, rf_wd, rf_we, expv[i]);
            end
        end
    endtask

    task automatic test_select();
        cyc(1, 32'hFFFF_FFFC, 32'h5555_0000, 32'h0, 5'd3, 1, 2'd2, 3'd0, 0, 0);
        n_tests++;
        if (rf_wd !== 32'h0) begin
            n_fail++; $display("FAIL sel_pc4_wrap got %h exp 00000000", rf_wd);
        end
        cyc(1, 32'h300, 32'h5555_AAAA, 32'h1111_1111, 5'd3, 1, 2'd3, 3'd0, 0, 0);
        n_tests++;
        if (rf_wd !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL sel_11_alu got %h exp 5555aaaa", rf_wd);
        end
    endtask

    task automatic test_x0_bubble();
        logic [31:0] c0;
        bubble(); bubble();
        c0 = m_cnt;
        cyc(1, 32'h600, 32'h77, 32'h0, 5'd0, 1, 2'd0, 3'd0, 0, 0);
        n_tests++;
        if (rf_we !== 1'b0 || wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL x0_write got we=%b valid=%b exp we=0 valid=1", rf_we, wb_valid);
        end
        cyc(0, 32'h604, 32'h78, 32'h0, 5'd9, 1, 2'd0, 3'd0, 0, 0);
        n_tests++;
        if (retire_cnt !== c0 + 32'd1 || rf_we !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL bubble_state got cnt=%h we=%b valid=%b exp cnt=%h we=0 valid=0",
                               retire_cnt, rf_we, wb_valid, c0 + 32'd1);
        end
        bubble();
        n_tests++;
        if (retire_cnt !== c0 + 32'd1) begin
            n_fail++; $display("FAIL bubble_no_count got %h exp %h", retire_cnt, c0 + 32'd1);
        end
    endtask

    // Ten back-to-back ALU ops with a 3-cycle hold before op 4; with_flush kills the held entry
    task automatic run_stream(input logic with_flush, input string tag);
        logic [31:0] base, alu;
        logic [31:0] s_wd, s_pc;
        logic [4:0]  s_rd;
        bubble(); bubble();
        base = m_cnt;
        for (int i = 0; i < 10; i++) begin
            alu = $urandom;
            if (i == 4) begin
                s_wd = m_wd; s_pc = m_pc; s_rd = m_rd;
                for (int k = 0; k < 3; k++) begin
                    cyc(1, 32'h800 + 32'(4 * i), alu, 32'h0, 5'(i + 1), 1, 2'd0, 3'd0, 1,
                        with_flush && (k == 2));
                    n_tests++;
                    if (rf_wd !== s_wd || wb_pc !== s_pc || rf_wa !== s_rd || retire_cnt !== base + 32'd3 ||
                        wb_valid !== !(with_flush && k == 2)) begin
                        n_fail++; $display("FAIL %s_hold%0d got wd=%h pc=%h cnt=%h valid=%b exp wd=%h pc=%h cnt=%h",
                                           tag, k, rf_wd, wb_pc, retire_cnt, wb_valid, s_wd, s_pc, base + 32'd3);
                    end
                end
            end
            cyc(1, 32'h800 + 32'(4 * i), alu, 32'h0, 5'(i + 1), 1, 2'd0, 3'd0, 0, 0);
            n_tests++;
            if (rf_wd !== alu || rf_wa !== 5'(i + 1) || rf_we !== 1'b1 || retire_cnt !== m_cnt) begin
                n_fail++; $display("FAIL %s_op%0d got wd=%h wa=%0d we=%b cnt=%h exp wd=%h wa=%0d we=1 cnt=%h",
                                   tag, i, rf_wd, rf_wa, rf_we, retire_cnt, alu, i + 1, m_cnt);
            end
        end
        bubble();
        n_tests++;
        if (retire_cnt !== base + (with_flush ? 32'd9 : 32'd10)) begin
            n_fail++; $display("FAIL %s_final_cnt got %h exp %h", tag, retire_cnt,
                               base + (with_flush ? 32'd9 : 32'd10));
        end
    endtask

    task automatic test_hold();
        run_stream(0, "hold");
    endtask

    task automatic test_flush_hold();
        run_stream(1, "flush_hold");
    endtask

    task automatic test_wrap();
        bubble();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        cyc(1, 32'h900, 32'h1, 32'h0, 5'd4, 1, 2'd0, 3'd0, 0, 0);
        n_tests++;
        if (retire_cnt !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL wrap_preload got %h exp ffffffff", retire_cnt);
        end
        bubble();
        n_tests++;
        if (retire_cnt !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero got %h exp 00000000", retire_cnt);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        for (int i = 0; i < 300; i++) begin
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cyc($urandom_range(0, 4) != 0, $urandom, $urandom, $urandom, rd, 1'($urandom),
                2'($urandom), 3'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            n_tests++;
            if (rf_wd !== m_wd || rf_wa !== m_rd || rf_we !== exp_rf_we() || wb_valid !== m_valid ||
                wb_pc !== m_pc || retire_cnt !== m_cnt) begin
                n_fail++; $display("FAIL random_%0d got wd=%h wa=%0d we=%b v=%b pc=%h cnt=%h exp wd=%h wa=%0d we=%b v=%b pc=%h cnt=%h",
                                   i, rf_wd, rf_wa, rf_we, wb_valid, wb_pc, retire_cnt,
                                   m_wd, m_rd, exp_rf_we(), m_valid, m_pc, m_cnt);
            end
        end
    endtask

    initial begin
        hold = 0; flush = 0; mem_valid = 0; mem_rf_we = 0; mem_pc = 0; mem_alu_res = 0;
        mem_rdata = 0; mem_rd = 0; mem_wb_sel = 0; mem_funct3 = 0;
        test_reset();
        test_load();
        test_select();
        test_x0_bubble();
        test_hold();
        test_flush_hold();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
